uart_receiver: RTL and testbench

//  8N1 UART receive path; counterpart of the board-level UART TX.

---
 rtl/uart_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receive path. The asynchronous serial line is synchronised,
//   the start bit is qualified at mid-bit, eight data bits are sampled
//   LSB-first at the end of each bit period counted from that mid-bit
//   point, and the stop bit is checked the same way. A completed byte is
//   held in a one-entry buffer with a valid/ready handshake.
//
//   Build option: define UART_RX_MAJORITY_EN to make every sample (start,
//   data, stop) a 2-of-3 majority of the synchronised line over the three
//   cycles ending at the nominal sample cycle. Undefined: one sample at the
//   nominal cycle.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit time (>= 8)
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   uart_rx    in   serial line, idle high, asynchronous to clk
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  a byte is waiting in the holding register
//   rx_ready   in   consumer takes the byte when rx_valid & rx_ready
//   rx_busy    out  receiver is not idle
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   overrun    out  1-cycle pulse, byte completed while the buffer was full
// ----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 54
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic             rx_meta_q, rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             sample;
    logic             byte_done;
    logic             stop_bad;

`ifdef UART_RX_MAJORITY_EN
    // Two previous values of rx_s: [0] is one cycle back, [1] two cycles back.
    logic [1:0] hist_q, hist_d;

    assign hist_d = {hist_q[0], rx_s_q};
    assign sample = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= hist_d;
    end
`else
    assign sample = rx_s_q;
`endif

    // Frame sequencing. The counter restarts at every sample so each bit
    // is taken a whole bit period after the previous one, which places it
    // at mid-bit because the start bit was qualified at its own mid-point.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line back high at mid start bit was only a glitch.
                    state_d   = sample ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sample, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sample) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_d   = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                // A break holds the line low; only re-arm once it is released.
                cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register and handshake. A take and a completion in the same
    // cycle reload the buffer, so rx_valid stays high with the new byte.
    always_comb begin
        rx_valid_d  = rx_valid_q & ~rx_ready;
        rx_data_d   = rx_data_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the line-side flops reset to the idle level (1) so a
            // release from reset never looks like a start bit; the data
            // holding register is reset as well so rx_data reads 0 after reset.
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // values from before this edge, which keeps the two-flop
            // synchroniser two flops deep.
            rx_meta_q   <= uart_rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed frames into uart_receiver (CLKS_PER_BIT = 16). A behavioural
//   model schedules, per frame sent, the clock edge at which the byte (or a
//   framing error) must appear and tracks the one-entry buffer; a compare
//   process checks the DUT outputs against it every cycle out of reset.
//   Directed literal checks pin the model's results.
// ----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int C    = 16;
    localparam int HALF = (C - 1) / 2;
    // Edge (counted from the edge that first captures the start bit) at
    // which outputs update: 2 synchroniser edges, the half start bit, eight
    // data bit periods and one stop bit period.
    localparam int LAT  = 2 + (HALF + 1) + 9 * C;
    // uart_rx drive step whose value is seen by the nominal sample of data bit 0.
    localparam int SPIKE_BASE = HALF + 1 + C;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         due;
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_fe    = 1'b0;
    logic       exp_ovr   = 1'b0;

    initial begin
        logic       nv, fe, ov;
        logic [7:0] nd;
        ev_t        ev;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_valid = 1'b0;
                exp_data  = 8'h00;
                exp_fe    = 1'b0;
                exp_ovr   = 1'b0;
                evq.delete();
            end else begin
                cyc++;
                nv = exp_valid && !rx_ready;
                nd = exp_data;
                fe = 1'b0;
                ov = 1'b0;
                while (evq.size() > 0 && evq[0].due <= cyc) begin
                    ev = evq.pop_front();
                    if (ev.is_err) fe = 1'b1;
                    else if (!exp_valid || rx_ready) begin
                        nv = 1'b1;
                        nd = ev.data;
                    end else ov = 1'b1;
                end
                exp_valid = nv;
                exp_data  = nd;
                exp_fe    = fe;
                exp_ovr   = ov;
            end
        end
    end

    // ---------------- compare process + pulse monitors ----------------
    int         valid_cycles = 0;
    int         ovr_pulses   = 0;
    int         fe_pulses    = 0;
    logic [7:0] last_data    = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rx_valid", rx_valid, exp_valid);
                if (exp_valid) check("rx_data", rx_data, exp_data);
                check("frame_err", frame_err, exp_fe);
                check("overrun", overrun, exp_ovr);
                if (rx_valid) begin
                    valid_cycles++;
                    last_data = rx_data;
                end
                if (overrun)   ovr_pulses++;
                if (frame_err) fe_pulses++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a negedge; drives one 8N1 frame, one step per cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input logic spikes, input int abort_step,
                              input logic chk_busy);
        logic [9:0] frame;
        logic       v;
        int         n0;
        ev_t        ev;
        frame     = {stop_val, data, 1'b0};
        n0        = cyc + 1;
        ev.due    = n0 + LAT;
        ev.is_err = !stop_val;
        ev.data   = data;
`ifndef UART_RX_MAJORITY_EN
        // Without majority voting every spiked data sample reads inverted.
        if (spikes) ev.data = ~data;
`endif
        if (abort_step < 0) evq.push_back(ev);
        for (int i = 0; i < 10 * C; i++) begin
            v = frame[i / C];
            if (spikes)
                for (int k = 0; k < 8; k++)
                    if (i == SPIKE_BASE + C * k) v = ~v;
            if (i == abort_step) begin
                rst_n   = 1'b0;
                uart_rx = 1'b1;
                #1;
                check("abort_valid", rx_valid, 0);
                check("abort_data", rx_data, 0);
                check("abort_busy", rx_busy, 0);
                check("abort_fe", frame_err, 0);
                check("abort_ovr", overrun, 0);
                return;
            end
            uart_rx = v;
            @(negedge clk);
            if (chk_busy) begin
                if (i == 1)       check("busy_pre_detect", rx_busy, 0);
                if (i == 2)       check("busy_detect", rx_busy, 1);
                if (i == LAT - 1) check("busy_stop_sample", rx_busy, 1);
                if (i == LAT)     check("busy_after_stop", rx_busy, 0);
            end
        end
    endtask

    int vb, ob, fb;

    initial begin
        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_fe", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 with consumer always ready: one-cycle valid.
        rx_ready = 1'b1;
        vb = valid_cycles; ob = ovr_pulses; fb = fe_pulses;
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_valid_cycles", valid_cycles - vb, 1);
        check("a5_data", last_data, 8'hA5);
        check("a5_no_err", (fe_pulses - fb) + (ovr_pulses - ob), 0);

        // 4-cycle low glitch on the idle line.
        vb = valid_cycles; fb = fe_pulses;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * C) @(negedge clk);
        check("glitch_busy", rx_busy, 0);
        check("glitch_no_out", (valid_cycles - vb) + (fe_pulses - fb), 0);

        // 0x3C then 0xC3 back-to-back with the buffer never drained.
        rx_ready = 1'b0;
        ob = ovr_pulses;
        send_frame(8'h3C, 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_valid_held", rx_valid, 1);
        check("b2b_data_held", rx_data, 8'h3C);
        check("b2b_overrun_once", ovr_pulses - ob, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("b2b_drained", rx_valid, 0);
        repeat (2) @(negedge clk);

        // 0x55 with a low stop bit, then a 40-bit break.
        vb = valid_cycles; fb = fe_pulses;
        send_frame(8'h55, 1'b0, 1'b0, -1, 1'b0);
        repeat (20 * C) @(negedge clk);
        check("break_busy", rx_busy, 1);
        repeat (20 * C) @(negedge clk);
        check("break_fe_once", fe_pulses - fb, 1);
        check("break_no_valid", valid_cycles - vb, 0);
        uart_rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("break_released", rx_busy, 0);
        send_frame(8'h0F, 1'b1, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("after_break_data", rx_data, 8'h0F);
        check("after_break_valid", rx_valid, 1);

        // Reset in the middle of data bit 3 of 0xFF, buffer still full.
        send_frame(8'hFF, 1'b1, 1'b0, 4 * C + C / 2, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, -1, 1'b0);
        repeat (4) @(negedge clk);
        check("post_reset_data", last_data, 8'h81);

        // 0x99 with a one-cycle inverted spike at every data sample point.
        send_frame(8'h99, 1'b1, 1'b1, -1, 1'b0);
        repeat (4) @(negedge clk);
`ifdef UART_RX_MAJORITY_EN
        check("spike_data", last_data, 8'h99);
`else
        check("spike_data", last_data, 8'h66);
`endif
        check("spike_idle", rx_busy, 0);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
